// File: rtl/shift_add_multiplier_4.sv
// =============================================================================
// Module   : shift_add_multiplier_4 (with ripple_carry_adder_4)
// Brief    : 4x4 unsigned shift-and-add multiplier, one add/shift step per clock.
//            Optional macro MUL_ZERO_SKIP_EN: zero operands finish in one edge.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module ripple_carry_adder_4 #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  logic [N:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign o_sum[gi]       = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
    assign w_carry[gi + 1] = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
  end

  assign o_cout = w_carry[N];

endmodule

module shift_add_multiplier_4 #(
  parameter int N = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic           o_busy,
  output logic           o_valid,
  output logic [2*N-1:0] o_product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] C_LAST_STEP = 2'd3;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_m;
  logic [N-1:0] r_acc;
  logic [N-1:0] r_q;
  logic [1:0]   r_count;

  logic         w_load;
  logic         w_zero_op;
  logic [N-1:0] w_addend;
  logic [N-1:0] w_sum;
  logic         w_cout;

`ifdef MUL_ZERO_SKIP_EN
  assign w_zero_op = (i_a == '0) || (i_b == '0);
`else
  assign w_zero_op = 1'b0;
`endif

  assign w_addend = r_q[0] ? r_m : '0;

  ripple_carry_adder_4 #(
    .N (N)
  ) u_adder (
    .i_a    (r_acc),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // The DONE edge doubles as an IDLE edge so a held i_start restarts every 5 cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_load      = 1'b1;
          w_state_nxt = w_zero_op ? S_DONE : S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_count == C_LAST_STEP) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_m     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_count <= '0;
    end else if (w_load) begin
      r_m     <= i_a;
      r_acc   <= '0;
      r_q     <= w_zero_op ? '0 : i_b;
      r_count <= '0;
    end else if (r_state == S_CALC) begin
      // Carry-out enters the top of acc so 0xF*0xF keeps every bit.
      {r_acc, r_q} <= {w_cout, w_sum, r_q[N-1:1]};
      r_count      <= r_count + 2'd1;
    end
  end

  assign o_busy    = (r_state != S_IDLE);
  assign o_valid   = (r_state == S_DONE);
  assign o_product = {r_acc, r_q};

endmodule

`default_nettype wire
